stopwatch_fnd_ctrl: RTL

//  Downstream consumer of the stopwatch datapath. Takes the live msec/sec/min/hour counts,

---
 rtl/stopwatch_fnd_ctrl_pkg.sv | 32 +++
 rtl/stopwatch_fnd_ctrl_seg_decoder.sv | 27 ++
 rtl/stopwatch_fnd_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/stopwatch_fnd_ctrl_pkg.sv
// stopwatch_fnd_pkg: shared segment codes, widths and BCD helper for the FND controller
package stopwatch_fnd_pkg;

    localparam int DIG_W = 2;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] COM_OFF   = 4'hF;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Saturate to 99 so a two-digit field never shows garbage, then split.
    function automatic bcd_t to_bcd(input logic [6:0] v);
        logic [6:0] s;
        s = (v >= 7'd100) ? 7'd99 : v;
        to_bcd.tens = 4'(s / 7'd10);
        to_bcd.ones = 4'(s % 7'd10);
    endfunction

endpackage

// File: rtl/stopwatch_fnd_ctrl_seg_decoder.sv
// fnd_seg_decoder: BCD digit to active-low a..g segments, 10..15 blank
module fnd_seg_decoder
    import stopwatch_fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Lookup of the {g..a} part of each digit code; non-decimal codes stay dark.
    always_comb begin
        seg = SEG_BLANK[6:0];
        case (bcd)
            4'd0: seg = SEG_0[6:0];
            4'd1: seg = SEG_1[6:0];
            4'd2: seg = SEG_2[6:0];
            4'd3: seg = SEG_3[6:0];
            4'd4: seg = SEG_4[6:0];
            4'd5: seg = SEG_5[6:0];
            4'd6: seg = SEG_6[6:0];
            4'd7: seg = SEG_7[6:0];
            4'd8: seg = SEG_8[6:0];
            4'd9: seg = SEG_9[6:0];
            default: seg = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/stopwatch_fnd_ctrl.sv
// stopwatch_fnd_ctrl: frame-snapshotted 4-digit multiplexed FND driver (FND_DOT_BLINK_EN: blinking separator dot)
module stopwatch_fnd_ctrl
    import stopwatch_fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       disp_sel,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] scan_cnt;
    logic             scan_tick;
    logic [DIG_W-1:0] digit_sel;
    logic [6:0]       snap_msec;
    logic [5:0]       snap_sec;
    logic [5:0]       snap_min;
    logic [4:0]       snap_hour;
    logic             sel_q;
    bcd_t             hi;
    bcd_t             lo;
    logic [3:0]       digit;
    logic [6:0]       seg;
    logic             dp;

    assign scan_tick = scan_cnt == CNT_W'(SCAN_DIV - 1);

    // Digit-slot timer: one tick per SCAN_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
    end

    // Active digit advances once per slot and wraps after digit3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digit_sel <= '0;
        else if (scan_tick)
            digit_sel <= digit_sel + 1'b1;
    end

    // Latch inputs only at the frame boundary so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
            sel_q     <= 1'b0;
        end else if (scan_tick && (&digit_sel)) begin
            snap_msec <= msec;
            snap_sec  <= sec;
            snap_min  <= min;
            snap_hour <= hour;
            sel_q     <= disp_sel;
        end
    end

    // Choose the displayed pair, split to BCD and pick the active digit and dot.
    always_comb begin
        hi    = to_bcd(sel_q ? {2'b00, snap_hour} : {1'b0, snap_sec});
        lo    = to_bcd(sel_q ? {1'b0, snap_min} : snap_msec);
        digit = (digit_sel == 2'd0) ? lo.ones :
                (digit_sel == 2'd1) ? lo.tens :
                (digit_sel == 2'd2) ? hi.ones : hi.tens;
`ifdef FND_DOT_BLINK_EN
        dp    = !((digit_sel == 2'd2) && (snap_msec < 7'd50));
`else
        dp    = digit_sel != 2'd2;
`endif
    end

    fnd_seg_decoder u_dec (
        .bcd (digit),
        .seg (seg)
    );

    // Register the pins so common and segment lines switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fnd_com  <= COM_OFF;
            fnd_data <= SEG_BLANK;
        end else begin
            fnd_com  <= ~(4'b1 << digit_sel);
            fnd_data <= {dp, seg};
        end
    end

endmodule
